// File: rtl/shift_reg_sequencer.sv
// Sequencer for an external 4-bit load/shift-right register: loads a word, issues k shift
// pulses while streaming the shifted-out bits, then captures the final contents.
// Requires 2**CNT_W > WIDTH so the clamped count fits in cnt.
module shift_reg_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [CNT_W-1:0] shamt,
    output logic [WIDTH-1:0] reg_d,
    output logic             reg_load,
    output logic             reg_sh,
    input  logic [WIDTH-1:0] reg_q,
    output logic             serial_out,
    output logic             serial_valid,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] k_clamp;
    logic [WIDTH-1:0] d_lat;

    // Shifting more than WIDTH times gives the same all-zero word, so cap the pulse count.
    assign k_clamp = (shamt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shamt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt    <= '0;
            d_lat  <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        d_lat <= din;
                        cnt   <= k_clamp;
                    end
                end
                SHIFT:   cnt    <= cnt - CNT_W'(1);
                CAPTURE: result <= reg_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt    = state;
        reg_d        = d_lat;
        reg_load     = 1'b0;
        reg_sh       = 1'b0;
        serial_out   = 1'b0;
        serial_valid = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                reg_load  = 1'b1;
                state_nxt = (cnt == '0) ? CAPTURE : SHIFT;
            end
            SHIFT: begin
                reg_sh       = 1'b1;
                serial_valid = 1'b1;
                serial_out   = reg_q[0];
                // cnt never reaches 0 here; <= 1 keeps a corrupted count from wrapping.
                if (cnt <= CNT_W'(1)) state_nxt = CAPTURE;
            end
            CAPTURE: state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Bench for shift_reg_sequencer: behavioural register, transaction-level reference model
// feeding an expectation queue, and a monitor comparing every cycle.
module tb_shift_reg_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       start;
    logic [3:0] din;
    logic [2:0] shamt;
    logic [3:0] reg_d;
    logic       reg_load;
    logic       reg_sh;
    logic [3:0] reg_q;
    logic       serial_out;
    logic       serial_valid;
    logic [3:0] result;
    logic       busy;
    logic       done;

    shift_reg_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .CLK(CLK), .RST(RST), .start(start), .din(din), .shamt(shamt),
        .reg_d(reg_d), .reg_load(reg_load), .reg_sh(reg_sh), .reg_q(reg_q),
        .serial_out(serial_out), .serial_valid(serial_valid), .result(result),
        .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         acc;
        int         k;
        logic [3:0] din;
        logic [3:0] res;
    } txn_t;

    txn_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         edge_n = 0;
    int         busy_left = 0;
    logic [3:0] last_din = '0;
    logic [3:0] ext_q;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", nm, act, exp, edge_n);
        end
    endtask

    // External register per the load/shift-right contract.
    initial begin
        ext_q = '0;
        forever begin
            @(posedge CLK);
            if (reg_load)    ext_q <= reg_d;
            else if (reg_sh) ext_q <= ext_q >> 1;
        end
    end
    assign reg_q = ext_q;

    // Reference model: an op accepted at edge a occupies the block until edge a+k+3.
    initial begin
        forever begin
            @(posedge CLK);
            edge_n++;
            if (RST) begin
                busy_left = 0;
                last_din  = '0;
                exp_q.delete();
            end else if (busy_left > 0) begin
                busy_left--;
            end else if (start) begin
                txn_t t;
                t.acc = edge_n;
                t.k   = (int'(shamt) > 4) ? 4 : int'(shamt);
                t.din = din;
                t.res = din >> t.k;
                last_din  = din;
                busy_left = t.k + 3;
                exp_q.push_back(t);
            end
        end
    end

    // Monitor: samples mid-low-phase, after stimulus driven at the falling edge settles.
    initial begin
        logic [3:0] last_res;
        int         sh_seen;
        last_res = '0;
        sh_seen  = 0;
        forever begin
            @(negedge CLK);
            #2;
            if (RST) begin
                chk("rst_reg_d", int'(reg_d), 0);
                chk("rst_reg_load", int'(reg_load), 0);
                chk("rst_reg_sh", int'(reg_sh), 0);
                chk("rst_serial_out", int'(serial_out), 0);
                chk("rst_serial_valid", int'(serial_valid), 0);
                chk("rst_result", int'(result), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                last_res = '0;
                sh_seen  = 0;
            end else begin
                txn_t t;
                bit   has, e_load, e_sh, e_done;
                int   e_bit;
                logic [3:0] e_res;
                has = exp_q.size() > 0;
                if (has) t = exp_q[0];
                e_load = has && edge_n == t.acc;
                e_sh   = has && edge_n > t.acc && edge_n <= t.acc + t.k;
                e_done = has && edge_n == t.acc + t.k + 2;
                e_bit  = e_sh ? ((int'(t.din) >> (edge_n - t.acc - 1)) & 1) : 0;
                e_res  = (has && edge_n >= t.acc + t.k + 2) ? t.res : last_res;
                chk("load_sh_exclusive", int'(reg_load & reg_sh), 0);
                chk("reg_load", int'(reg_load), int'(e_load));
                chk("reg_sh", int'(reg_sh), int'(e_sh));
                chk("serial_valid", int'(serial_valid), int'(e_sh));
                chk("serial_out", int'(serial_out), e_bit);
                chk("reg_d", int'(reg_d), int'(last_din));
                chk("busy", int'(busy), int'(busy_left > 0));
                chk("done", int'(done), int'(e_done));
                chk("result", int'(result), int'(e_res));
                if (reg_sh) sh_seen++;
                if (e_done) begin
                    chk("shift_pulses", sh_seen, t.k);
                    last_res = t.res;
                    sh_seen  = 0;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            #3;
            if (busy_left == 0 && exp_q.size() == 0) return;
        end
        chk("idle_timeout", 1, 0);
    endtask

    task automatic run_op(input logic [3:0] d, input logic [2:0] s);
        @(negedge CLK);
        din   = d;
        shamt = s;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_idle();
    endtask

    task automatic reset_mid_op(input logic [3:0] d, input logic [2:0] s, input int dly);
        @(negedge CLK);
        din   = d;
        shamt = s;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (dly) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        wait_idle();
    endtask

    initial begin
        RST   = 1'b1;
        start = 1'b0;
        din   = '0;
        shamt = '0;
        repeat (3) @(negedge CLK);
        // Release reset with start already high: the first edge must accept it.
        RST   = 1'b0;
        din   = 4'b1011;
        shamt = 3'd2;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_idle();

        run_op(4'b1001, 3'd0);
        run_op(4'b1111, 3'd7);
        run_op(4'b1000, 3'd4);
        run_op(4'b0101, 3'd5);

        // Start held high; starts while busy must be ignored.
        @(negedge CLK);
        shamt = 3'd1;
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 0) din = din + 4'd1;
            @(negedge CLK);
        end
        start = 1'b0;
        wait_idle();

        reset_mid_op(4'b0110, 3'd3, 2);
        run_op(4'b0110, 3'd1);

        for (int n = 0; n < 80; n++) begin
            logic [3:0] d;
            logic [2:0] s;
            d = 4'($urandom_range(0, 15));
            s = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) begin
                reset_mid_op(d, s, int'($urandom_range(0, 6)));
            end else begin
                repeat ($urandom_range(0, 3)) @(negedge CLK);
                run_op(d, s);
            end
        end

        repeat (4) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
